// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: FSM states,
// key-code field helpers and the chatter LFSR seed/taps.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } emu_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Taps 8,6,5,4 expressed as register bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [1:0] key_col(input logic [3:0] key);
      return key[3:2];
   endfunction

   function automatic logic [1:0] key_row(input logic [3:0] key);
      return key[1:0];
   endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-command channel from the test controller to the keypad emulator.
interface keypad_cmd_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_key;
   logic [CNT_W-1:0] cmd_hold;
   logic             cmd_bounce;

   modport master (output cmd_valid, cmd_key, cmd_hold, cmd_bounce, input cmd_ready);
   modport slave  (input cmd_valid, cmd_key, cmd_hold, cmd_bounce, output cmd_ready);
endinterface

// File: rtl/keypad_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; its low bit drives contact chatter.
module keypad_lfsr8
   import keypad_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic ph1,
   input  logic reset,
   output logic lsb
);

   logic [7:0] q;

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) q <= SEED;
      else       q <= {q[6:0], ^(q & LFSR_TAPS)};
   end

   assign lsb = q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Responder end of a 4x4 column-drive/row-sense keypad: closes one key on
// command, with optional chatter, a hold counted in column strobes, and a gap.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_SCANS    = 4,
   parameter int BOUNCE_CYCLES = 8,
   parameter int GAP_CYCLES    = 16,
   parameter int CNT_W         = 8
) (
   input  logic             ph1,
   input  logic             reset,
   input  logic [3:0]       cols,
   output logic [3:0]       rows,
   keypad_cmd_if.slave      cmd,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] strobes_seen
);

   localparam logic [CNT_W-1:0] HOLD_DEF    = CNT_W'(HOLD_SCANS);
   localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

   emu_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] strobes_nxt;
   logic [CNT_W-1:0] hold_target;
   logic [3:0]       key;
   logic [3:0]       cols_prev;
   logic [1:0]       kcol;
   logic [1:0]       krow;
   logic             bounce_en;
   logic             contact;
   logic             accept;
   logic             strobe;
   logic             done_nxt;
   logic             chatter;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   keypad_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .ph1   (ph1),
      .reset (reset),
      .lsb   (chatter)
   );

   assign kcol          = key_col(key);
   assign krow          = key_row(key);
   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign strobe        = cols[kcol] & ~cols_prev[kcol];

   // Row sense is purely combinational so the scanner sees the contact in the same cycle it drives a column
   always_comb begin
      rows       = '0;
      rows[krow] = contact & cols[kcol];
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      strobes_nxt = strobes_seen;
      contact     = 1'b0;
      done_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               strobes_nxt = '0;
               if (cmd.cmd_bounce) begin
                  state_nxt = BOUNCE_IN;
                  cnt_nxt   = BOUNCE_LOAD;
               end else begin
                  state_nxt = HOLD;
               end
            end
         end
         BOUNCE_IN: begin
            contact = chatter;
            if (cnt == '0) state_nxt = HOLD;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         HOLD: begin
            contact = 1'b1;
            if (strobe) begin
               strobes_nxt = sat_inc(strobes_seen);
               if (strobes_nxt == hold_target) begin
                  if (bounce_en) begin
                     state_nxt = BOUNCE_OUT;
                     cnt_nxt   = BOUNCE_LOAD;
                  end else begin
                     state_nxt = GAP;
                     cnt_nxt   = GAP_LOAD;
                  end
               end
            end
         end
         BOUNCE_OUT: begin
            contact = chatter;
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         strobes_seen <= '0;
         key          <= '0;
         hold_target  <= HOLD_DEF;
         bounce_en    <= 1'b0;
         cols_prev    <= '0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         strobes_seen <= strobes_nxt;
         cols_prev    <= cols;
         done         <= done_nxt;
         if (accept) begin
            key         <= cmd.cmd_key;
            hold_target <= (cmd.cmd_hold == '0) ? HOLD_DEF : cmd.cmd_hold;
            bounce_en   <= cmd.cmd_bounce;
         end
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed-vector bench for keypad_emulator with hand-derived expectations.
module tb_keypad_emulator;

   logic       ph1;
   logic       reset;
   logic [3:0] cols;
   logic [3:0] rows;
   logic       busy;
   logic       done;
   logic [7:0] strobes_seen;
   logic [7:0] lfsr_m;

   int checks = 0;
   int errors = 0;

   keypad_cmd_if #(.CNT_W(8)) cmd_if ();

   keypad_emulator #(
      .HOLD_SCANS    (4),
      .BOUNCE_CYCLES (8),
      .GAP_CYCLES    (16),
      .CNT_W         (8)
   ) dut (
      .ph1          (ph1),
      .reset        (reset),
      .cols         (cols),
      .rows         (rows),
      .cmd          (cmd_if),
      .busy         (busy),
      .done         (done),
      .strobes_seen (strobes_seen)
   );

   initial ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   // Reference chatter source: Fibonacci taps 8,6,5,4 from seed A5
   always @(posedge ph1 or posedge reset) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   task automatic step();
      @(posedge ph1);
      #1;
   endtask

   task automatic send(input logic [3:0] key, input logic [7:0] hold, input logic bounce);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_key    = key;
      cmd_if.cmd_hold   = hold;
      cmd_if.cmd_bounce = bounce;
      step();
      cmd_if.cmd_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      #1;
      checks++; if (rows !== 4'b0000) begin errors++; $display("FAIL reset_rows: got %b expected 0000", rows); end
      checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (strobes_seen !== 8'd0) begin errors++; $display("FAIL reset_strobes: got %0d expected 0", strobes_seen); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: ready=%b busy=%b expected 1/0", cmd_if.cmd_ready, busy);
      end
      step();
   endtask

   task automatic test_simple_press();
      logic [3:0] exp_rows;
      cols = 4'b0000;
      send(4'h9, 8'd3, 1'b0);
      for (int k = 0; k <= 28; k++) begin
         cols = 4'b0001 << (k % 4);
         #1;
         exp_rows = (k <= 10 && (k % 4) == 2) ? 4'b0010 : 4'b0000;
         checks++; if (rows !== exp_rows) begin errors++; $display("FAIL simple_rows k=%0d: got %b expected %b", k, rows, exp_rows); end
         checks++; if (done !== (k == 27)) begin errors++; $display("FAIL simple_done k=%0d: got %b expected %b", k, done, (k == 27)); end
         checks++; if (cmd_if.cmd_ready !== (k >= 27)) begin errors++; $display("FAIL simple_ready k=%0d: got %b expected %b", k, cmd_if.cmd_ready, (k >= 27)); end
         if (k == 27) begin
            checks++; if (strobes_seen !== 8'd3) begin errors++; $display("FAIL simple_strobes: got %0d expected 3", strobes_seen); end
         end
         step();
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp_rows;
      cols = 4'b0000;
      send(4'h0, 8'd1, 1'b1);
      for (int k = 0; k <= 39; k++) begin
         cols = (k == 12) ? 4'b0000 : 4'b0001;
         #1;
         if (k <= 7 || (k >= 14 && k <= 21)) exp_rows = {3'b000, lfsr_m[0]};
         else if (k <= 13 && k != 12)        exp_rows = 4'b0001;
         else                                exp_rows = 4'b0000;
         checks++; if (rows !== exp_rows) begin errors++; $display("FAIL bounce_rows k=%0d: got %b expected %b", k, rows, exp_rows); end
         checks++; if (done !== (k == 38)) begin errors++; $display("FAIL bounce_done k=%0d: got %b expected %b", k, done, (k == 38)); end
         if (k == 12) begin
            checks++; if (strobes_seen !== 8'd0) begin errors++; $display("FAIL bounce_static_strobes: got %0d expected 0", strobes_seen); end
         end
         if (k == 14) begin
            checks++; if (strobes_seen !== 8'd1) begin errors++; $display("FAIL bounce_strobes: got %0d expected 1", strobes_seen); end
         end
         step();
      end
   endtask

   task automatic test_default_hold();
      logic [3:0] exp_rows;
      cols = 4'b0000;
      send(4'h5, 8'd0, 1'b0);
      for (int k = 0; k <= 31; k++) begin
         cols = 4'b0001 << (k % 4);
         #1;
         exp_rows = (k <= 13 && (k % 4) == 1) ? 4'b0010 : 4'b0000;
         checks++; if (rows !== exp_rows) begin errors++; $display("FAIL dflt_rows k=%0d: got %b expected %b", k, rows, exp_rows); end
         checks++; if (done !== (k == 30)) begin errors++; $display("FAIL dflt_done k=%0d: got %b expected %b", k, done, (k == 30)); end
         if (k == 12) begin
            checks++; if (strobes_seen !== 8'd3) begin errors++; $display("FAIL dflt_strobes_mid: got %0d expected 3", strobes_seen); end
         end
         if (k == 14 || k == 30) begin
            checks++; if (strobes_seen !== 8'd4) begin errors++; $display("FAIL dflt_strobes k=%0d: got %0d expected 4", k, strobes_seen); end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_rows;
      logic [3:0] kv;
      cols = 4'b0000;
      send(4'h9, 8'd1, 1'b0);
      cmd_if.cmd_valid = 1'b1;
      for (int k = 0; k <= 38; k++) begin
         kv = k[3:0];
         cols = 4'b0001 << (k % 4);
         if (k < 19)       cmd_if.cmd_key = kv ^ 4'hA;
         else if (k == 19) cmd_if.cmd_key = 4'h4;
         else begin
            cmd_if.cmd_valid = 1'b0;
            cmd_if.cmd_key   = 4'hD;
         end
         #1;
         if (k == 2)       exp_rows = 4'b0010;
         else if (k == 21) exp_rows = 4'b0001;
         else              exp_rows = 4'b0000;
         checks++; if (rows !== exp_rows) begin errors++; $display("FAIL b2b_rows k=%0d: got %b expected %b", k, rows, exp_rows); end
         checks++; if (cmd_if.cmd_ready !== (k == 19 || k >= 38)) begin
            errors++; $display("FAIL b2b_ready k=%0d: got %b expected %b", k, cmd_if.cmd_ready, (k == 19 || k >= 38));
         end
         checks++; if (done !== (k == 19 || k == 38)) begin
            errors++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, done, (k == 19 || k == 38));
         end
         step();
      end
   endtask

   task automatic test_wrong_column();
      cols = 4'b0000;
      send(4'hF, 8'd2, 1'b0);
      for (int k = 0; k < 30; k++) begin
         cols = 4'b0001 << (k % 3);
         #1;
         checks++; if (rows !== 4'b0000) begin errors++; $display("FAIL wrongcol_rows k=%0d: got %b expected 0000", k, rows); end
         step();
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrongcol_busy: got %b expected 1", busy); end
      checks++; if (strobes_seen !== 8'd0) begin errors++; $display("FAIL wrongcol_strobes: got %0d expected 0", strobes_seen); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrongcol_recover: busy=%b expected 0", busy); end
      step();
   endtask

   task automatic test_reset_mid_hold();
      cols = 4'b0000;
      send(4'h6, 8'd5, 1'b0);
      cols = 4'b0010;
      step();
      step();
      #1;
      checks++; if (rows !== 4'b0100) begin errors++; $display("FAIL midrst_pre_rows: got %b expected 0100", rows); end
      checks++; if (strobes_seen !== 8'd1) begin errors++; $display("FAIL midrst_pre_strobes: got %0d expected 1", strobes_seen); end
      #1 reset = 1'b1;
      #1;
      checks++; if (rows !== 4'b0000) begin errors++; $display("FAIL midrst_rows: got %b expected 0000", rows); end
      checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", cmd_if.cmd_ready); end
      checks++; if (strobes_seen !== 8'd0) begin errors++; $display("FAIL midrst_strobes: got %0d expected 0", strobes_seen); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || rows !== 4'b0000) begin
         errors++; $display("FAIL midrst_after: busy=%b rows=%b expected 0/0000", busy, rows);
      end
      step();
   endtask

   initial begin
      reset             = 1'b1;
      cols              = 4'b0000;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_key    = 4'h0;
      cmd_if.cmd_hold   = 8'd0;
      cmd_if.cmd_bounce = 1'b0;
      test_reset();
      test_simple_press();
      test_bounce();
      test_default_hold();
      test_back_to_back();
      test_wrong_column();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
